// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data-memory stage: funct3 width codes,
// fault cause encodings and small decode helpers used by the top level.
package dmem_pkg;

  // Load/store width codes taken straight from the instruction funct3 field.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fault cause encodings reported on fault_cause.
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_RANGE    = 2'b11;

  // Loads accept B, H, W, BU, HU; everything else is illegal.
  function automatic logic load_f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Stores have no unsigned forms, so any funct3[2]=1 is illegal, as is 011.
  function automatic logic store_f3_illegal(input logic [2:0] f3);
    return f3[2] || (f3 == 3'b011);
  endfunction

  // Alignment depends only on the size bits funct3[1:0].
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: builds byte enables and replicated
// store data for SB/SH/SW, and extracts plus sign/zero-extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lane_data,
  output logic [31:0] load_data
);

  logic [31:0] load_shifted;

  // Store side: replicate the source across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    byte_en         = 4'b0000;
    store_lane_data = store_data;
    case (funct3[1:0])
      2'b00: begin
        byte_en         = 4'b0001 << lane;
        store_lane_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_en         = lane[1] ? 4'b1100 : 4'b0011;
        store_lane_data = {2{store_data[15:0]}};
      end
      2'b10: begin
        byte_en         = 4'b1111;
        store_lane_data = store_data;
      end
      default: byte_en = 4'b0000;
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend per funct3.
  always_comb begin
    load_shifted = load_word >> {lane, 3'b000};
    load_data    = '0;
    case (funct3)
      F3_B:    load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      F3_H:    load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'h0, load_shifted[7:0]};
      F3_HU:   load_data = {16'h0, load_shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data-memory stage of the single-cycle RV32I core: combinational loads,
// byte-masked stores on the clock edge, and a sticky first-fault register.
// Optional macro DMEM_BOUNDS_CHECK_EN: when defined, addresses beyond the
// array raise an out-of-range fault instead of wrapping.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024  // power of two, at least 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      read_word;
  logic [3:0]       byte_en;
  logic [31:0]      store_lane_data;
  logic [31:0]      load_data;

  logic             access;
  logic             illegal;
  logic             out_of_range;
  logic [1:0]       cause;
  logic             fault;
  logic             store_en;

  logic             fault_valid_d, fault_valid_q;
  logic [1:0]       fault_cause_d, fault_cause_q;
  logic [31:0]      fault_addr_d,  fault_addr_q;

  assign word_idx  = addr[IDX_W+1:2];
  assign lane      = addr[1:0];
  assign read_word = mem_q[word_idx];

  dmem_lane_align u_lane_align (
    .funct3          (funct3),
    .lane            (lane),
    .store_data      (wdata),
    .load_word       (read_word),
    .byte_en         (byte_en),
    .store_lane_data (store_lane_data),
    .load_data       (load_data)
  );

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = access && (|addr[31:IDX_W+2]);
`else
  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_upper_addr;
  assign unused_upper_addr = ^addr[31:IDX_W+2];
  assign out_of_range      = 1'b0;
`endif

  // Classify the current access and pick the highest-priority fault cause.
  always_comb begin
    access     = mem_read || mem_write;
    illegal    = (mem_read && load_f3_illegal(funct3)) ||
                 (mem_write && store_f3_illegal(funct3));
    misaligned = access && is_misaligned(funct3, lane);
    if (illegal)           cause = CAUSE_ILLEGAL;
    else if (misaligned)   cause = CAUSE_MISALIGN;
    else if (out_of_range) cause = CAUSE_RANGE;
    else                   cause = CAUSE_NONE;
    fault    = (cause != CAUSE_NONE);
    store_en = mem_write && !fault;
    rdata    = (mem_read && !fault) ? load_data : '0;
  end

  // Byte-masked store; reads above see the pre-write contents in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset -- contents are undefined until written, which keeps it RAM-mappable.
    for (int b = 0; b < 4; b++) begin
      if (store_en && byte_en[b]) begin
        mem_q[word_idx][8*b +: 8] <= store_lane_data[8*b +: 8];
      end
    end
  end

  // Next state of the sticky fault register: first fault wins, clear re-arms capture.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    if (fault_clear) begin
      fault_valid_d = 1'b0;
      fault_cause_d = CAUSE_NONE;
      fault_addr_d  = '0;
    end
    if (fault && (!fault_valid_q || fault_clear)) begin
      fault_valid_d = 1'b1;
      fault_cause_d = cause;
      fault_addr_d  = addr;
    end
  end

  // Fault register state, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      fault_valid_q <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_data_memory;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, fault_clear;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, fault_addr;
  logic        misaligned, fault_valid;
  logic [1:0]  fault_cause;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  data_memory #(.DEPTH_WORDS(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .misaligned  (misaligned),
    .fault_valid (fault_valid),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timed out");
  end

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: got %h required <scoreboard entry>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic check_fault(input string tag, input logic v, input logic [1:0] c,
                             input logic [31:0] a);
    push_exp({31'b0, v});
    push_exp({30'b0, c});
    push_exp(a);
    check({tag, "_valid"}, {31'b0, fault_valid});
    check({tag, "_cause"}, {30'b0, fault_cause});
    check({tag, "_addr"},  fault_addr);
  endtask

  // Apply one access and wait to the falling edge, where combinational outputs are sampled.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic clr);
    mem_read    = rd;
    mem_write   = wr;
    funct3      = f3;
    addr        = a;
    wdata       = wd;
    fault_clear = clr;
    @(negedge clk);
  endtask

  // Let the rising edge commit the access, then return the bus to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    fault_clear = 1'b0;
    funct3      = F3_W;
    addr        = '0;
    wdata       = '0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    push_exp(exp);
    drive(1'b1, 1'b0, f3, a, 32'h0, 1'b0);
    check(tag, rdata);
    tick();
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b0, 1'b1, f3, a, wd, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; fault_clear = 1'b0;
    funct3 = F3_W; addr = '0; wdata = '0;
    #2;
    check_fault("reset", 1'b0, CAUSE_NONE, 32'h0);
    push_exp(32'h0);
    check("reset_rdata", rdata);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Word store, then word and byte loads with both extensions.
    store(F3_W, 32'h10, 32'h8899AABB);
    load_chk("lw_10",  F3_W,  32'h10, 32'h8899AABB);
    load_chk("lb_13",  F3_B,  32'h13, 32'hFFFFFF88);
    load_chk("lbu_13", F3_BU, 32'h13, 32'h00000088);
    load_chk("lh_10",  F3_H,  32'h10, 32'hFFFFAABB);
    load_chk("lhu_12", F3_HU, 32'h12, 32'h00008899);

    // Partial stores leave the other bytes intact.
    store(F3_B, 32'h11, 32'h000000CC);
    load_chk("lw_after_sb", F3_W, 32'h10, 32'h8899CCBB);
    store(F3_H, 32'h12, 32'h00001234);
    load_chk("lw_after_sh", F3_W, 32'h10, 32'h1234CCBB);
    load_chk("lh_12",       F3_H, 32'h12, 32'h00001234);

    // Misaligned word load is captured; a later misaligned SH is neither stored nor captured.
    store(F3_W, 32'h04, 32'h11223344);
    push_exp(32'h0);
    push_exp(32'h1);
    drive(1'b1, 1'b0, F3_W, 32'h22, 32'h0, 1'b0);
    check("lw_22_rdata", rdata);
    check("lw_22_misaligned", {31'b0, misaligned});
    tick();
    check_fault("mis_lw", 1'b1, CAUSE_MISALIGN, 32'h22);
    push_exp(32'h1);
    drive(1'b0, 1'b1, F3_H, 32'h05, 32'h0000FFFF, 1'b0);
    check("sh_05_misaligned", {31'b0, misaligned});
    tick();
    check_fault("first_wins", 1'b1, CAUSE_MISALIGN, 32'h22);
    load_chk("lw_04_kept", F3_W, 32'h04, 32'h11223344);

    // Clear, then an illegal store is suppressed and captured as cause 10.
    store(F3_W, 32'h30, 32'hDEADBEEF);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    tick();
    push_exp(32'h0);
    check("clear1_valid", {31'b0, fault_valid});
    store(3'b100, 32'h30, 32'h00000000);
    check_fault("ill_st", 1'b1, CAUSE_ILLEGAL, 32'h30);
    load_chk("lw_30_kept", F3_W, 32'h30, 32'hDEADBEEF);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    tick();
    push_exp(32'h0);
    check("clear2_valid", {31'b0, fault_valid});
    // Clear together with a new fault captures the new fault.
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    tick();
    store(F3_W, 32'h0, 32'h0);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 1'b0, F3_H, 32'h31, 32'h0, 1'b0);
    tick();
    check_fault("mis_lh_31", 1'b1, CAUSE_MISALIGN, 32'h31);
    drive(1'b1, 1'b0, F3_W, 32'h8, 32'h0, 1'b1);
    tick();
    push_exp(32'h0);
    check("clear3_valid", {31'b0, fault_valid});
    store(3'b110, 32'h40, 32'h0);
    drive(1'b1, 1'b0, F3_H, 32'h31, 32'h0, 1'b1);
    tick();
    check_fault("clr_plus_fault", 1'b1, CAUSE_MISALIGN, 32'h31);

    // Asynchronous reset between clock edges; memory survives.
    #3 rst = 1'b1;
    #1;
    check_fault("async_rst", 1'b0, CAUSE_NONE, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    load_chk("lw_after_rst", F3_W, 32'h10, 32'h1234CCBB);

`ifdef DMEM_BOUNDS_CHECK_EN
    store(F3_W, 32'h0, 32'h0);
    store(F3_W, 32'h1000, 32'hCAFEF00D);
    check_fault("range", 1'b1, CAUSE_RANGE, 32'h1000);
    load_chk("lw_0_untouched", F3_W, 32'h0, 32'h0);
    load_chk("lw_range_zero", F3_W, 32'h1000, 32'h0);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    tick();
`else
    store(F3_W, 32'h1000, 32'hCAFEF00D);
    load_chk("lw_0_wrap", F3_W, 32'h0, 32'hCAFEF00D);
    check_fault("no_range", 1'b0, CAUSE_NONE, 32'h0);
`endif

    // Illegal load funct3 returns zero and is captured.
    load_chk("ld_f3_011", 3'b011, 32'h10, 32'h0);
    check_fault("ill_ld", 1'b1, CAUSE_ILLEGAL, 32'h10);

    // No enables: rdata is zero even at a written address.
    push_exp(32'h0);
    drive(1'b0, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    check("idle_rdata", rdata);
    tick();

    // Simultaneous read and write: read shows pre-write data, write commits.
    store(F3_W, 32'h40, 32'hA5A5A5A5);
    push_exp(32'hA5A5A5A5);
    drive(1'b1, 1'b1, F3_W, 32'h40, 32'h5A5A5A5A, 1'b0);
    check("rw_prewrite", rdata);
    tick();
    load_chk("rw_committed", F3_W, 32'h40, 32'h5A5A5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data-memory stage of the single-cycle RV32I core.
- Sits directly downstream of the ALU: consumes the ALU result as the effective byte address, performs loads and stores, and returns load data to the writeback mux.
- Handles RV32I byte, half and word widths with sign/zero extension.
- Records the first access fault (misaligned, illegal width or out-of-range) in a sticky fault register.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, minimum 4.
- IDX_W, log2(DEPTH_WORDS), word index width; derived, not overridden.

Ports:
- clk  in  1  core clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  load enable.
- mem_write  in  1  store enable.
- funct3  in  3  access width/sign from the instruction.
- addr  in  32  effective byte address from the ALU result.
- wdata  in  32  store data (rs2).
- rdata  out  32  load data, extended to 32 bits.
- misaligned  out  1  combinational flag for the current access.
- fault_valid  out  1  sticky flag: a fault has been captured.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 out-of-range.
- fault_addr  out  32  address of the captured fault.
- fault_clear  in  1  clears the sticky fault register.

Behaviour:
- Reset: rst is asynchronous and active-high. rst=1 forces fault_valid=0, fault_cause=00 and fault_addr=0. The memory array is not reset.
- Word index is addr[IDX_W+1:2]. Byte lane is addr[1:0].
- Loads are combinational, with 0-cycle latency, so rdata is valid in the same cycle.
  - funct3 000 (LB): sign-extended byte.
  - 001 (LH): sign-extended half.
  - 010 (LW): full word.
  - 100 (LBU): zero-extended byte.
  - 101 (LHU): zero-extended half.
  - rdata=0 when mem_read=0 or the access faults.
- Stores commit on the rising clk edge when mem_write=1 and the access does not fault.
  - 000 (SB): writes lane addr[1:0] only.
  - 001 (SH): writes lane pair addr[1].
  - 010 (SW): writes all 4 bytes.
  - Unwritten bytes keep their old value.
- Misaligned:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00.
  - Asserted only while mem_read or mem_write is high.
  - A misaligned store is suppressed and leaves memory unchanged.
- Illegal funct3:
  - loads: 011, 110, 111;
  - stores: any funct3 with funct3[2]=1, or 011.
  - An illegal access is suppressed, and rdata=0.
- Fault priority: illegal funct3 > misaligned > out-of-range.
- Fault capture, on the clk edge:
  - If fault_valid=0 and a faulting access occurs, load fault_valid=1, fault_cause and fault_addr=addr.
  - While fault_valid=1, later faults are ignored (first fault wins).
  - fault_clear=1 with no new fault gives fault_valid=0 next edge.
  - fault_clear=1 together with a new fault captures the new fault.
- mem_read and mem_write both high: the write commits at the edge, and rdata in that cycle shows pre-write data.
- No enables active: no state change, and rdata=0.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Any addr with bits [31:IDX_W+2] nonzero is out-of-range (cause 11).
  - Out-of-range stores are suppressed, and loads return 0.
- Undefined:
  - Upper address bits are ignored, and accesses wrap modulo DEPTH_WORDS*4.
  - Cause 11 is never produced.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - fault cause constants CAUSE_NONE, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_RANGE.
- Sub-module dmem_lane_align is purely combinational. It generates the 4-bit byte-enable and the lane-shifted write data for stores, and extracts and extends load data.
- The top level holds the array, the fault register and the fault priority logic.

Test Plan:
- SW addr=0x10 wdata=0x8899AABB, then LW addr=0x10 -> rdata=0x8899AABB; LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088.
- SB addr=0x11 wdata=0x000000CC onto word 0x8899AABB -> LW 0x10 returns 0x8899CCBB; SH 0x12 wdata=0x1234 -> 0x1234CCBB; LH 0x12 -> 0x00001234.
- LW addr=0x22 -> misaligned=1, rdata=0, next edge fault_valid=1, cause=01, fault_addr=0x22; a following SH at 0x05 is ignored by the fault register and memory is unchanged.
- Store funct3=100 at 0x30 -> memory unchanged, cause 10 captured; fault_clear pulsed -> fault_valid=0; clear plus a misaligned LH at 0x31 in the same cycle -> fault_valid=1, cause=01, addr=0x31.
- rst asserted mid-cycle with fault_valid=1 -> outputs go to 0 immediately, without waiting for clk; memory contents are retained.
- With DMEM_BOUNDS_CHECK_EN defined and DEPTH_WORDS=1024, SW at 0x1000 -> suppressed, cause 11. Without the macro, SW at 0x1000 then LW at 0x0 -> the stored word is read back.
